sccb_master: RTL and testbench

- SCCB (OV-camera serial control bus) master. Sits directly downstream of the PC packet decoder.
- Accepts one register read or write request at a time, then serialises it onto sccb_c/sccb_d.
- Returns read data with a done pulse; the decoder loops that data back into its output FIFO.
- Runs on the receive clock domain.

---
 rtl/sccb_master.sv | 264 ++++++++++++++++++++++++++
 tb/tb_sccb_master.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sccb_master: SCCB register read/write master with quarter-bit ticks.   |
// | Optional macro SCCB_ACK_CHECK_EN enables slave ACK checking (nack).    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sccb_master #(
  parameter logic [15:0] CLK_DIV = 16'd250,
  parameter logic [7:0]  DEV_ID  = 8'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       read_request,
  input  logic       write_request,
  input  logic [7:0] addr,
  input  logic [7:0] write_data,
  output logic [7:0] read_data,
  output logic       request_ack,
  output logic       done,
  output logic       busy,
  output logic       nack,
  output logic       sccb_c,
  output logic       sccb_d_o,
  output logic       sccb_d_oe,
  input  logic       sccb_d_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_BYTE  = 3'd2,
    S_STOP  = 3'd3,
    S_GAP   = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  phase_q, phase_d;
  logic [3:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic        half_q, half_d;
  logic        op_rd_q, op_rd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  read_data_q, read_data_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        nack_q, nack_d;
  logic        c_q, c_d;
  logic        d_q, d_d;
  logic        oe_q, oe_d;

  logic        tick;
  logic        rx_byte;
  logic        last_byte;
  logic        rx_next;
  logic [7:0]  tx_byte;

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    phase_d     = phase_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    half_d      = half_q;
    op_rd_d     = op_rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    shift_d     = shift_q;
    read_data_d = read_data_q;
    nack_d      = nack_q;
    ack_d       = 1'b0;
    done_d      = 1'b0;

    tick      = (tick_cnt_q == 16'd0);
    rx_byte   = op_rd_q && half_q && (byte_q == 2'd1);
    last_byte = op_rd_q ? (byte_q == 2'd1) : (byte_q == 2'd2);

    if (state_q != S_IDLE && state_q != S_DONE) begin
      tick_cnt_d = tick ? (CLK_DIV - 16'd1) : (tick_cnt_q - 16'd1);
    end

    case (state_q)
      S_IDLE: begin
        if (write_request || read_request) begin
          state_d    = S_START;
          tick_cnt_d = CLK_DIV - 16'd1;
          phase_d    = 2'd0;
          half_d     = 1'b0;
          op_rd_d    = !write_request;
          addr_d     = addr;
          wdata_d    = write_data;
          nack_d     = 1'b0;
          ack_d      = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          if (phase_q == 2'd0) begin
            phase_d = 2'd1;
          end else begin
            state_d = S_BYTE;
            phase_d = 2'd0;
            bit_d   = 4'd0;
            byte_d  = 2'd0;
          end
        end
      end
      S_BYTE: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd2) begin
            if (rx_byte && bit_q != 4'd8) begin
              shift_d = {shift_q[6:0], sccb_d_i};
            end
`ifdef SCCB_ACK_CHECK_EN
            if (!rx_byte && bit_q == 4'd8 && sccb_d_i) begin
              nack_d = 1'b1;
            end
`endif
          end
          if (phase_q == 2'd3) begin
            if (bit_q != 4'd8) begin
              bit_d = bit_q + 4'd1;
            end else begin
              bit_d = 4'd0;
              if (last_byte || nack_q) begin
                state_d = S_STOP;
              end else begin
                byte_d = byte_q + 2'd1;
              end
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (phase_q != 2'd2) begin
            phase_d = phase_q + 2'd1;
          end else begin
            phase_d = 2'd0;
            // A NACK in the first read frame skips the data frame entirely.
            if (op_rd_q && !half_q && !nack_q) begin
              state_d = S_GAP;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
              if (op_rd_q && !nack_q) begin
                read_data_d = shift_q;
              end
            end
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d = S_START;
            half_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        tick_cnt_d = 16'd0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);

    // Bus pins are registered from the position being entered, so they move only on ticks.
    case (byte_d)
      2'd0:    tx_byte = half_d ? (DEV_ID | 8'h01) : DEV_ID;
      2'd1:    tx_byte = addr_d;
      default: tx_byte = wdata_d;
    endcase
    rx_next = op_rd_d && half_d && (byte_d == 2'd1);

    c_d  = 1'b1;
    d_d  = 1'b1;
    oe_d = 1'b1;
    case (state_d)
      S_START: begin
        d_d = (phase_d == 2'd0);
      end
      S_BYTE: begin
        c_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        if (bit_d == 4'd8) begin
          oe_d = rx_next;
        end else if (rx_next) begin
          oe_d = 1'b0;
        end else begin
          d_d = tx_byte[3'd7 - bit_d[2:0]];
        end
      end
      S_STOP: begin
        c_d = (phase_d != 2'd0);
        d_d = (phase_d == 2'd2);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= 16'd0;
      phase_q     <= 2'd0;
      bit_q       <= 4'd0;
      byte_q      <= 2'd0;
      half_q      <= 1'b0;
      op_rd_q     <= 1'b0;
      addr_q      <= 8'd0;
      wdata_q     <= 8'd0;
      shift_q     <= 8'd0;
      read_data_q <= 8'd0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      nack_q      <= 1'b0;
      c_q         <= 1'b1;
      d_q         <= 1'b1;
      oe_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      half_q      <= half_d;
      op_rd_q     <= op_rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      shift_q     <= shift_d;
      read_data_q <= read_data_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      nack_q      <= nack_d;
      c_q         <= c_d;
      d_q         <= d_d;
      oe_q        <= oe_d;
    end
  end

  assign read_data   = read_data_q;
  assign request_ack = ack_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign nack        = nack_q;
  assign sccb_c      = c_q;
  assign sccb_d_o    = d_q;
  assign sccb_d_oe   = oe_q;

endmodule
`default_nettype wire

// File: tb/tb_sccb_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_sccb_master: randomized bench with a protocol-level bus decoder.    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_sccb_master;

  localparam logic [15:0] CDIV = 16'd4;
  localparam logic [7:0]  DEV  = 8'h42;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       read_request = 1'b0;
  logic       write_request = 1'b0;
  logic [7:0] addr = 8'd0;
  logic [7:0] write_data = 8'd0;
  logic [7:0] read_data;
  logic       request_ack, done, busy, nack;
  logic       sccb_c, sccb_d_o, sccb_d_oe;
  logic       sccb_d_i;

  always #5 clk = ~clk;

  sccb_master #(.CLK_DIV(CDIV), .DEV_ID(DEV)) dut (
    .clk(clk), .rst(rst), .read_request(read_request), .write_request(write_request),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .request_ack(request_ack), .done(done), .busy(busy), .nack(nack),
    .sccb_c(sccb_c), .sccb_d_o(sccb_d_o), .sccb_d_oe(sccb_d_oe), .sccb_d_i(sccb_d_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decoded bus: {ack_line, ack_oe, data_oe_any, data_oe_all, byte}
  logic [11:0] mon_q[$];
  int   starts = 0, stops = 0, done_cnt = 0, cyc = 0;
  int   byte_idx = 0, bit_idx = 0, drv_byte = 0, drv_bit = 0;
  logic frame_rd = 1'b0, prev_c = 1'b1, prev_l = 1'b1, oe_any = 1'b0, oe_all = 1'b1;
  logic [7:0] sh = 8'd0;
  logic [7:0] slave_rdata = 8'd0;
  int   slave_nack_byte = -1;
  logic line_w;
  logic [2:0] bsel;

  assign line_w = sccb_d_oe ? sccb_d_o : sccb_d_i;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (done === 1'b1) done_cnt++;
    if (prev_c && sccb_c && prev_l && !line_w) begin
      starts++;
      byte_idx = 0; bit_idx = 0; drv_byte = 0; drv_bit = 0;
      frame_rd = 1'b0; oe_any = 1'b0; oe_all = 1'b1;
    end else if (prev_c && sccb_c && !prev_l && line_w) begin
      stops++;
    end else if (!prev_c && sccb_c) begin
      if (bit_idx < 8) begin
        sh = {sh[6:0], line_w};
        oe_any = oe_any | sccb_d_oe;
        oe_all = oe_all & sccb_d_oe;
        bit_idx++;
      end else begin
        mon_q.push_back({line_w, sccb_d_oe, oe_any, oe_all, sh});
        if (byte_idx == 0) frame_rd = sh[0];
        byte_idx++;
        bit_idx = 0; oe_any = 1'b0; oe_all = 1'b1;
      end
    end else if (prev_c && !sccb_c) begin
      drv_byte = byte_idx;
      drv_bit  = bit_idx;
    end
    prev_c = sccb_c;
    prev_l = line_w;
  end

  // Slave: supplies read data on the data byte, ACKs (or NACKs) master-written bytes.
  always_comb begin
    sccb_d_i = 1'b1;
    bsel     = 3'(7 - drv_bit);
    if (frame_rd && drv_byte == 1) begin
      if (drv_bit < 8) sccb_d_i = slave_rdata[bsel];
    end else if (drv_bit == 8) begin
      sccb_d_i = (drv_byte == slave_nack_byte);
    end
  end

  function automatic int nack_eff(input int nb);
`ifdef SCCB_ACK_CHECK_EN
    return nb;
`else
    return -1;
`endif
  endfunction

  function automatic int exp_ticks(input bit wr, input int nk);
    if (nk >= 0) return 2 + 36 * (nk + 1) + 3;
    if (wr)      return 2 + 36 * 3 + 3;
    return 2 * (2 + 36 * 2 + 3) + 4;
  endfunction

  task automatic wait_ack(output int t);
    int k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (request_ack !== 1'b1 && k < 50);
    check("ack_seen", request_ack, 1);
    check("busy_at_ack", busy, 1);
    t = cyc;
  endtask

  task automatic wait_done(input int t_ack, input int ticks, output int t_done);
    int k = 0;
    bit busy_ok = 1'b1;
    bit ack_once = 1'b1;
    do begin
      @(posedge clk); #1; k++;
      if (request_ack !== 1'b0) ack_once = 1'b0;
      if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
    end while (done !== 1'b1 && k < 2000);
    check("done_latency", cyc - t_ack, ticks * CDIV);
    check("busy_in_done", busy, 0);
    check("busy_held", busy_ok, 1);
    check("ack_single", ack_once, 1);
    t_done = cyc;
  endtask

  task automatic check_bus(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] rd, input int sl_nack, input int s0, input int p0);
    logic [7:0] eb[4];
    int nk = nack_eff(sl_nack);
    int nb = (nk >= 0) ? nk + 1 : (wr ? 3 : 4);
    int nf = (wr || nk >= 0) ? 1 : 2;
    logic [3:0] ef;
    eb[0] = DEV; eb[1] = a; eb[2] = wr ? wd : (DEV | 8'h01); eb[3] = rd;
    check("n_start", starts - s0, nf);
    check("n_stop", stops - p0, nf);
    check("n_bytes", mon_q.size(), nb);
    for (int i = 0; i < nb && i < mon_q.size(); i++) begin
      ef = (!wr && i == 3) ? 4'b1100 : {(i == sl_nack), 3'b011};
      check("bus_byte", mon_q[i][7:0], eb[i]);
      check("bus_flags", mon_q[i][11:8], ef);
    end
    mon_q.delete();
  endtask

  task automatic do_op(input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] rd, input int sl_nack);
    int s0 = starts;
    int p0 = stops;
    int ta, td;
    int nk = nack_eff(sl_nack);
    logic [7:0] rd_before = read_data;
    mon_q.delete();
    slave_rdata = rd;
    slave_nack_byte = sl_nack;
    @(negedge clk);
    addr = a; write_data = wd; write_request = wr; read_request = !wr;
    wait_ack(ta);
    write_request = 1'b0; read_request = 1'b0;
    addr = ~a; write_data = ~wd;
    wait_done(ta, exp_ticks(wr, nk), td);
    check_bus(wr, a, wd, rd, sl_nack, s0, p0);
    check("nack", nack, (nk >= 0));
    @(posedge clk); #1;
    check("read_data", read_data, (wr || nk >= 0) ? rd_before : rd);
    check("idle_bus", {sccb_c, sccb_d_o, sccb_d_oe}, 3'b111);
    slave_nack_byte = -1;
  endtask

  initial begin : main
    int ta, td, ta2, td2, s0, p0, dc;
    // Reset with a request pending: no ack, bus high.
    rst = 1'b0; write_request = 1'b1; addr = 8'h55; write_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_ack", request_ack, 0);
      check("rst_bus", {sccb_c, sccb_d_o, sccb_d_oe}, 3'b111);
      check("rst_busy", busy, 0);
      check("rst_rdata", read_data, 0);
      check("rst_nack", nack, 0);
    end
    @(negedge clk); write_request = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ack", request_ack, 0);

    do_op(1'b1, 8'h12, 8'h80, 8'h00, -1);
    do_op(1'b0, 8'h0A, 8'h00, 8'h76, -1);

    // Both requests: write wins; the held read starts on the first IDLE edge after done.
    s0 = starts; p0 = stops; mon_q.delete(); slave_rdata = 8'h5C;
    @(negedge clk);
    addr = 8'h33; write_data = 8'hC4; write_request = 1'b1; read_request = 1'b1;
    wait_ack(ta);
    write_request = 1'b0;
    wait_done(ta, exp_ticks(1'b1, -1), td);
    check_bus(1'b1, 8'h33, 8'hC4, 8'h00, -1, s0, p0);
    s0 = starts; p0 = stops;
    wait_ack(ta2);
    check("held_read_accept", ta2 - td, 2);
    read_request = 1'b0;
    wait_done(ta2, exp_ticks(1'b0, -1), td2);
    check_bus(1'b0, 8'h33, 8'h00, 8'h5C, -1, s0, p0);
    @(posedge clk); #1;
    check("held_read_data", read_data, 8'h5C);

    // Reset in the middle of the first byte of a write.
    @(negedge clk);
    addr = 8'h21; write_data = 8'h9E; write_request = 1'b1;
    wait_ack(ta);
    write_request = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk); rst = 1'b0; dc = done_cnt;
    @(posedge clk); #1;
    check("abort_bus", {sccb_c, sccb_d_o, sccb_d_oe}, 3'b111);
    check("abort_busy", busy, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt - dc, 0);
    do_op(1'b0, 8'h3C, 8'h00, 8'hE1, -1);

    // Slave NACKs the address byte of a write.
    do_op(1'b1, 8'h44, 8'h99, 8'h00, 1);

    for (int i = 0; i < 8; i++) begin
      do_op(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
